// File: rtl/wb_ram_slave_if.sv
// Wishbone single-transfer bus between a master and wb_ram_slave.
interface wb_ram_slave_if #(
  parameter int unsigned WORD = 16
);
  logic            cyc_i;
  logic            stb_i;
  logic            we_i;
  logic [1:0]      sel_i;
  logic [WORD-1:0] adr_i;
  logic [WORD-1:0] dat_i;
  logic            ack_o;
  logic            err_o;
  logic [WORD-1:0] dat_o;

  modport slave (
    input  cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
    output ack_o, err_o, dat_o
  );

  modport master (
    output cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
    input  ack_o, err_o, dat_o
  );
endinterface

// File: rtl/wb_ram_slave.sv
// Wishbone slave RAM: byte-lane writes, masked registered reads, fixed wait
// states, err_o for out-of-range or empty-select accesses.
module wb_ram_slave #(
  parameter int unsigned WORD        = 16,
  parameter int unsigned ADDR_BITS   = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  wb_ram_slave_if.slave  wb
);
  localparam int unsigned LANE  = WORD / 2;
  localparam int unsigned DEPTH = 2 ** ADDR_BITS;
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] idx_q, idx_d;
  logic                 bad_q, bad_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic [WORD-1:0]      dat_q, dat_d;
  logic [WORD-1:0]      mem_q [DEPTH];

  logic                 req;
  logic                 enter_resp;
  logic                 wr_lo, wr_hi;
  logic [WORD-1:0]      rd_word;
  logic [LANE-1:0]      rd_lo, rd_hi;
  logic                 unused_adr0;

  assign unused_adr0 = wb.adr_i[0];

  always_comb begin
    req        = wb.cyc_i & wb.stb_i;
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    bad_d      = bad_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    dat_d      = dat_q;
    enter_resp = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          idx_d = wb.adr_i[ADDR_BITS:1];
          bad_d = (wb.adr_i[WORD-1:ADDR_BITS+1] != '0) || (wb.sel_i == 2'b00);
          if (WS == 4'd0) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
            cnt_d      = '0;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WS;
          end
        end
      end
      ST_WAIT: begin
        if (!req) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd1) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_HOLD;
      ST_HOLD: if (!wb.stb_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // idx_d/bad_d already hold this request's decode, including the
    // zero-wait case where RESP is entered on the request edge itself.
    rd_word = mem_q[idx_d];
    rd_lo   = wb.sel_i[0] ? rd_word[LANE-1:0]    : '0;
    rd_hi   = wb.sel_i[1] ? rd_word[WORD-1:LANE] : '0;

    if (enter_resp) begin
      if (bad_d) begin
        err_d = 1'b1;
        dat_d = '0;
      end else begin
        ack_d = 1'b1;
        if (!wb.we_i) dat_d = {rd_hi, rd_lo};
      end
    end

    wr_lo = enter_resp & ~bad_d & wb.we_i & wb.sel_i[0];
    wr_hi = enter_resp & ~bad_d & wb.we_i & wb.sel_i[1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      bad_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      bad_q   <= bad_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  // Contents survive reset; a reset on the RESP-entry edge suppresses the write.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (wr_lo) mem_q[idx_d][LANE-1:0]    <= wb.dat_i[LANE-1:0];
      if (wr_hi) mem_q[idx_d][WORD-1:LANE] <= wb.dat_i[WORD-1:LANE];
    end
  end

  assign wb.ack_o = ack_q;
  assign wb.err_o = err_q;
  assign wb.dat_o = dat_q;
endmodule

// File: tb/tb_wb_ram_slave.sv
// Directed scoreboard bench: three slaves with WAIT_STATES 1, 3 and 0.
module tb_wb_ram_slave;
  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [1:0]  sel;
  logic [15:0] adr, dat;
  int unsigned cur;
  logic        ack, err;
  logic [15:0] dout;

  always #5 clk = ~clk;

  wb_ram_slave_if #(.WORD(16)) bus_a ();
  wb_ram_slave_if #(.WORD(16)) bus_b ();
  wb_ram_slave_if #(.WORD(16)) bus_c ();

  assign bus_a.cyc_i = cyc && (cur == 0);
  assign bus_a.stb_i = stb && (cur == 0);
  assign bus_a.we_i  = we;
  assign bus_a.sel_i = sel;
  assign bus_a.adr_i = adr;
  assign bus_a.dat_i = dat;
  assign bus_b.cyc_i = cyc && (cur == 1);
  assign bus_b.stb_i = stb && (cur == 1);
  assign bus_b.we_i  = we;
  assign bus_b.sel_i = sel;
  assign bus_b.adr_i = adr;
  assign bus_b.dat_i = dat;
  assign bus_c.cyc_i = cyc && (cur == 2);
  assign bus_c.stb_i = stb && (cur == 2);
  assign bus_c.we_i  = we;
  assign bus_c.sel_i = sel;
  assign bus_c.adr_i = adr;
  assign bus_c.dat_i = dat;

  always_comb begin
    case (cur)
      1:       begin ack = bus_b.ack_o; err = bus_b.err_o; dout = bus_b.dat_o; end
      2:       begin ack = bus_c.ack_o; err = bus_c.err_o; dout = bus_c.dat_o; end
      default: begin ack = bus_a.ack_o; err = bus_a.err_o; dout = bus_a.dat_o; end
    endcase
  end

  wb_ram_slave #(.WORD(16), .ADDR_BITS(10), .WAIT_STATES(1)) dut_a (
    .clk_i(clk), .rst_i(rst), .wb(bus_a.slave));
  wb_ram_slave #(.WORD(16), .ADDR_BITS(10), .WAIT_STATES(3)) dut_b (
    .clk_i(clk), .rst_i(rst), .wb(bus_b.slave));
  wb_ram_slave #(.WORD(16), .ADDR_BITS(10), .WAIT_STATES(0)) dut_c (
    .clk_i(clk), .rst_i(rst), .wb(bus_c.slave));

  typedef struct {
    logic        is_err;
    logic        chk_dat;
    logic [15:0] dat;
    int unsigned lat;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic int unsigned ws_of(int unsigned c);
    return (c == 1) ? 3 : (c == 2) ? 0 : 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input string tag, input logic w, input logic [1:0] s,
                      input logic [15:0] a, input logic [15:0] d,
                      input logic is_err, input logic [15:0] exp_dat,
                      input int unsigned hold);
    exp_t        e;
    int unsigned lat;
    sb.push_back('{is_err, (!w) || is_err, exp_dat, ws_of(cur) + 1});
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; dat = d;
    lat = 0;
    while (!(ack || err) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    if (!(ack || err)) begin
      check({tag, "-timeout"}, 32'(lat), 32'(e.lat));
    end else begin
      check({tag, "-lat"}, 32'(lat), 32'(e.lat));
      check({tag, "-ack"}, 32'(ack), 32'(!e.is_err));
      check({tag, "-err"}, 32'(err), 32'(e.is_err));
      if (e.chk_dat) check({tag, "-dat"}, 32'(dout), 32'(e.dat));
    end
    for (int i = 0; i < int'(hold); i++) begin
      @(negedge clk);
      check({tag, "-hold"}, 32'({ack, err}), 32'(0));
    end
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    check({tag, "-single"}, 32'({ack, err}), 32'(0));
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 2'b00;
    adr = '0; dat = '0; cur = 0;
    repeat (2) @(negedge clk);
    check("rst-ack", 32'(ack), 32'(0));
    check("rst-err", 32'(err), 32'(0));
    check("rst-dat", 32'(dout), 32'(0));
    rst = 1'b0;

    xfer("wr_beef", 1'b1, 2'b11, 16'h0010, 16'hBEEF, 1'b0, 16'h0000, 0);
    xfer("rd_beef", 1'b0, 2'b11, 16'h0010, 16'h0000, 1'b0, 16'hBEEF, 0);

    xfer("wr_1234", 1'b1, 2'b11, 16'h0002, 16'h1234, 1'b0, 16'h0000, 0);
    xfer("wr_ab00", 1'b1, 2'b10, 16'h0002, 16'hAB00, 1'b0, 16'h0000, 0);
    xfer("rd_sel11", 1'b0, 2'b11, 16'h0002, 16'h0000, 1'b0, 16'hAB34, 0);
    xfer("rd_sel01", 1'b0, 2'b01, 16'h0002, 16'h0000, 1'b0, 16'h0034, 0);
    xfer("rd_sel10", 1'b0, 2'b10, 16'h0002, 16'h0000, 1'b0, 16'hAB00, 0);

    xfer("wr_cafe", 1'b1, 2'b11, 16'h0000, 16'hCAFE, 1'b0, 16'h0000, 0);
    xfer("err_range", 1'b1, 2'b11, 16'h0800, 16'h9999, 1'b1, 16'h0000, 0);
    xfer("rd_cafe0", 1'b0, 2'b11, 16'h0000, 16'h0000, 1'b0, 16'hCAFE, 0);
    xfer("err_rdsel0", 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b1, 16'h0000, 0);
    xfer("err_wrsel0", 1'b1, 2'b00, 16'h0000, 16'h1111, 1'b1, 16'h0000, 0);
    xfer("rd_cafe1", 1'b0, 2'b11, 16'h0000, 16'h0000, 1'b0, 16'hCAFE, 0);

    xfer("wr_hold", 1'b1, 2'b11, 16'h0006, 16'h7777, 1'b0, 16'h0000, 5);
    xfer("rd_after_hold", 1'b0, 2'b11, 16'h0006, 16'h0000, 1'b0, 16'h7777, 0);

    cur = 1;
    xfer("b_wr", 1'b1, 2'b11, 16'h0004, 16'h1111, 1'b0, 16'h0000, 0);
    xfer("b_rd", 1'b0, 2'b11, 16'h0004, 16'h0000, 1'b0, 16'h1111, 0);

    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 2'b11; adr = 16'h0004; dat = 16'h5555;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort-noresp", 32'({ack, err}), 32'(0));
    end
    check("abort-dat", 32'(dout), 32'(16'h1111));
    xfer("b_rd_abort", 1'b0, 2'b11, 16'h0004, 16'h0000, 1'b0, 16'h1111, 0);

    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 2'b11; adr = 16'h0004; dat = 16'h5555;
    @(negedge clk);
    rst = 1'b1; cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("midrst-dat", 32'(dout), 32'(0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("midrst-noresp", 32'({ack, err}), 32'(0));
    end
    xfer("b_rd_rst", 1'b0, 2'b11, 16'h0004, 16'h0000, 1'b0, 16'h1111, 0);

    cur = 2;
    xfer("c_wr_ffff", 1'b1, 2'b11, 16'h0008, 16'hFFFF, 1'b0, 16'h0000, 0);
    xfer("c_wr_lo", 1'b1, 2'b01, 16'h0008, 16'h3C5A, 1'b0, 16'h0000, 0);
    xfer("c_rd", 1'b0, 2'b11, 16'h0008, 16'h0000, 1'b0, 16'hFF5A, 0);
    xfer("c_err", 1'b0, 2'b11, 16'h0C08, 16'h0000, 1'b1, 16'h0000, 2);

    check("sb-empty", 32'(sb.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
